xillybus_wrapper_mb_pipe: RTL
=============================

// Module: xillybus_wrapper_mb_pipe
// PURPOSE
//  Parametrised pipelined multiplier / multiply-accumulate for the xillybus_wrapper datapath.
//  - Next generation of the single-cycle 15x15 unsigned multiply unit.
//  - Adds NUM_STAGE register pipeline, clock enable, valid tracking and per-operation
//    signed/unsigned select.
//  - Adds optional accumulate into the result register.
// PARAMETERS
//  ID          32'd1   instance tag, no functional effect
//  NUM_STAGE   32'd3   latency in ce-qualified cycles, legal range >=1
//  din0_WIDTH  32'd15  operand A width
//  din1_WIDTH  32'd15  operand B width
//  dout_WIDTH  32'd30  result/accumulator width, must be >= din0_WIDTH+din1_WIDTH
// PORTS
//  clk         in   1           single clock, all state on rising edge
//  reset       in   1           synchronous, active-high; overrides ce
//  ce          in   1           clock enable; low = whole pipeline holds
//  din_valid   in   1           operands/controls valid this ce cycle
//  din_signed  in   1           1 = two's-complement operands, 0 = unsigned
//  din_acc     in   1           1 = add product to current dout, 0 = load product
//  din0        in   din0_WIDTH  operand A
//  din1        in   din1_WIDTH  operand B
//  dout_valid  out  1           dout carries a new result
//  dout        out  dout_WIDTH  result / accumulator
// BEHAVIOUR
//  - Reset (clk edge with reset=1):
//    - All stage valid bits, dout_valid and dout clear to 0.
//    - Operand stage registers may clear or hold; their value is don't-care.
//  - Advance: state changes only on edges with ce=1 and reset=0.
//    - ce=0 freezes every register, dout_valid included.
//    - A result held across a stall stays visible.
//  - Consume rule: the consumer takes a result on an edge where ce=1 and dout_valid=1.
//  - Latency: a token accepted at ce edge k appears on dout after the NUM_STAGE-th
//    ce=1 edge.
//    - Throughput is one token per ce cycle.
//    - Bubbles (din_valid=0) propagate as invalid slots.
//  - Product: P = din0*din1, extended to dout_WIDTH.
//    - din_signed=1: both operands sign-extended, signed product.
//    - din_signed=0: zero-extended, unsigned product.
//    - Control bits travel with the token through every stage.
//  - Final stage:
//    - Valid token, acc=0: dout <= P.
//    - Valid token, acc=1: dout <= dout + P, modulo 2^dout_WIDTH (silent wrap, no saturation).
//    - Invalid slot: dout holds and dout_valid <= 0.
//    - Accumulate uses the live dout register, so back-to-back acc tokens chain with no hazard.
//  - NUM_STAGE=1: multiply and load/accumulate in one registered stage.
//    - Extra stages are pure registers ahead of the final stage.
//    - Multiply sits in stage 1 so synthesis can retime into the DSP.
//  - Reset mid-operation: all in-flight tokens are discarded, no partial result is emitted.
//    - The first result after reset appears NUM_STAGE ce edges after the next accepted token.
//  - din_valid=1 while ce=0 is ignored; the token is not captured.
// STRUCTURE
//  - Shared package xillybus_wrapper_mb_pkg holds:
//    - MB_MODE_LOAD=1'b0, MB_MODE_ACC=1'b1
//    - MB_UNSIGNED=1'b0, MB_SIGNED=1'b1
//    - function mb_prod_width(a,b)
//  - Sub-module xillybus_wrapper_mb_pipe_DSP48_0 holds the pipeline core:
//    - Ports: clk, reset, ce, a, b, sgn, acc, vin, p, vout.
//    - The top level only checks parameters and wires ports.
//    - The top level raises an elaboration error if dout_WIDTH < din0_WIDTH+din1_WIDTH
//      or NUM_STAGE < 1.
// TESTING  (default params unless noted)
//  - Unsigned max: ce=1, din0=din1=15'h7FFF, signed=0, acc=0
//    -> after 3 edges dout=30'd1073676289, dout_valid=1 for exactly 1 cycle.
//  - Signed: din0=15'h7FFF (-1), din1=15'd2, signed=1
//    -> dout=30'h3FFFFFFE; same operands with signed=0 -> dout=30'd65534.
//  - Accumulate chain, back-to-back: (3,4,acc=0),(5,6,acc=1),(7,1,acc=1)
//    -> successive dout 12, 42, 49 on consecutive cycles.
//  - Wrap: (7FFF,7FFF,acc=0) then (7FFF,7FFF,acc=1), unsigned
//    -> second dout=30'd1073610754, no flag.
//  - Stall: token in flight, ce=0 for 5 cycles incl. with dout_valid=1
//    -> dout/dout_valid frozen; result emerges after 3 ce=1 edges total.
//  - Reset mid-stream: 3 tokens in flight, reset=1 one cycle (ce=0 too)
//    -> dout=0, dout_valid=0, no stale result ever emitted; NUM_STAGE=1 and 5 rerun all.

Source files
------------

// File: rtl/xillybus_wrapper_mb_pkg.sv
// Shared constants and helpers for the xillybus_wrapper multiply/accumulate pipe.
package xillybus_wrapper_mb_pkg;

    localparam logic MB_MODE_LOAD = 1'b0;
    localparam logic MB_MODE_ACC  = 1'b1;

    localparam logic MB_UNSIGNED  = 1'b0;
    localparam logic MB_SIGNED    = 1'b1;

    // Width of a full-precision product of an a-bit and a b-bit operand.
    function automatic int unsigned mb_prod_width(input int unsigned a, input int unsigned b);
        return a + b;
    endfunction

endpackage

// File: rtl/xillybus_wrapper_mb_pipe_if.sv
// Operand/result bundle of the multiply/accumulate pipe, including its clock enable.
interface xillybus_wrapper_mb_pipe_if #(
    parameter int unsigned din0_WIDTH = 32'd15,
    parameter int unsigned din1_WIDTH = 32'd15,
    parameter int unsigned dout_WIDTH = 32'd30
);
    logic                  ce;
    logic                  din_valid;
    logic                  din_signed;
    logic                  din_acc;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  dout_valid;
    logic [dout_WIDTH-1:0] dout;

    modport master (
        output ce, din_valid, din_signed, din_acc, din0, din1,
        input  dout_valid, dout
    );

    modport slave (
        input  ce, din_valid, din_signed, din_acc, din0, din1,
        output dout_valid, dout
    );
endinterface

// File: rtl/xillybus_wrapper_mb_pipe_DSP48_0.sv
// Pipeline core: multiply in stage 1, optional delay stages, load/accumulate in the last stage.
module xillybus_wrapper_mb_pipe_DSP48_0
    import xillybus_wrapper_mb_pkg::*;
#(
    parameter int unsigned NUM_STAGE = 32'd3,
    parameter int unsigned AW        = 32'd15,
    parameter int unsigned BW        = 32'd15,
    parameter int unsigned DW        = 32'd30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic          sgn,
    input  logic          acc,
    input  logic          vin,
    output logic [DW-1:0] p,
    output logic          vout
);

    logic [DW-1:0] a_ext_c;
    logic [DW-1:0] b_ext_c;
    logic [DW-1:0] prod_c;
    logic [DW-1:0] fin_prod_c;
    logic          fin_acc_c;
    logic          fin_vld_c;
    logic [DW-1:0] dout_d, dout_q;
    logic          vout_d, vout_q;

    // Extend operands to the result width and multiply; low DW bits are exact for both signednesses.
    always_comb begin
        a_ext_c = {{(DW-AW){(sgn == MB_SIGNED) & a[AW-1]}}, a};
        b_ext_c = {{(DW-BW){(sgn == MB_SIGNED) & b[BW-1]}}, b};
        prod_c  = a_ext_c * b_ext_c;
    end

    if (NUM_STAGE == 1) begin : g_direct
        assign fin_prod_c = prod_c;
        assign fin_acc_c  = acc;
        assign fin_vld_c  = vin;
    end else begin : g_pipe
        localparam int unsigned NR = NUM_STAGE - 1;

        logic [DW-1:0] prod_d [NR];
        logic [DW-1:0] prod_q [NR];
        logic [NR-1:0] acc_d, acc_q;
        logic [NR-1:0] vld_d, vld_q;

        // Shift product and its control bits one stage per enabled cycle.
        always_comb begin
            prod_d = prod_q;
            acc_d  = acc_q;
            vld_d  = vld_q;
            if (ce) begin
                prod_d[0] = prod_c;
                acc_d[0]  = acc;
                vld_d[0]  = vin;
                for (int i = 1; i < int'(NR); i++) begin
                    prod_d[i] = prod_q[i-1];
                    acc_d[i]  = acc_q[i-1];
                    vld_d[i]  = vld_q[i-1];
                end
            end
        end

        // Stage registers; only valid bits need clearing on reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= '0;
            end else begin
                prod_q <= prod_d;
                acc_q  <= acc_d;
                vld_q  <= vld_d;
            end
        end

        assign fin_prod_c = prod_q[NR-1];
        assign fin_acc_c  = acc_q[NR-1];
        assign fin_vld_c  = vld_q[NR-1];
    end

    // Final stage: load or accumulate into the live result register; bubbles hold dout.
    always_comb begin
        dout_d = dout_q;
        vout_d = vout_q;
        if (ce) begin
            vout_d = fin_vld_c;
            if (fin_vld_c) begin
                dout_d = (fin_acc_c == MB_MODE_ACC) ? dout_q + fin_prod_c : fin_prod_c;
            end
        end
    end

    // Result register and its valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            vout_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vout_q <= vout_d;
        end
    end

    assign p    = dout_q;
    assign vout = vout_q;

endmodule

// File: rtl/xillybus_wrapper_mb_pipe.sv
// Top of the pipelined multiply/accumulate unit: parameter checks and wiring only.
module xillybus_wrapper_mb_pipe
    import xillybus_wrapper_mb_pkg::*;
#(
    parameter int unsigned ID         = 32'd1,
    parameter int unsigned NUM_STAGE  = 32'd3,
    parameter int unsigned din0_WIDTH = 32'd15,
    parameter int unsigned din1_WIDTH = 32'd15,
    parameter int unsigned dout_WIDTH = 32'd30
) (
    input  logic                       clk,
    input  logic                       reset,
    xillybus_wrapper_mb_pipe_if.slave  bus
);

    if (dout_WIDTH < mb_prod_width(din0_WIDTH, din1_WIDTH)) begin : g_bad_width
        $error("xillybus_wrapper_mb_pipe %0d: dout_WIDTH %0d narrower than product", ID, dout_WIDTH);
    end

    if (NUM_STAGE < 1) begin : g_bad_stage
        $error("xillybus_wrapper_mb_pipe %0d: NUM_STAGE must be at least 1", ID);
    end

    xillybus_wrapper_mb_pipe_DSP48_0 #(
        .NUM_STAGE (NUM_STAGE),
        .AW        (din0_WIDTH),
        .BW        (din1_WIDTH),
        .DW        (dout_WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .ce    (bus.ce),
        .a     (bus.din0),
        .b     (bus.din1),
        .sgn   (bus.din_signed),
        .acc   (bus.din_acc),
        .vin   (bus.din_valid),
        .p     (bus.dout),
        .vout  (bus.dout_valid)
    );

endmodule
